// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low-level transmit path.
package usb_tx_pkg;

  // ST_LOAD is a zero-length decision point and is never held as a register value.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STUFF = 3'd4,
    ST_EOP   = 3'd5,
    ST_EIDLE = 3'd6
  } tx_state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [2:0] EOP_BITS     = 3'd2;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes on the last clock of each period.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign strobe = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/usb_tx_controller.sv
// USB packet serializer: SYNC, LSB-first payload with bit stuffing, EOP and EIDLE,
// producing raw bits and an SE0 request for the downstream NRZI encoder.
module usb_tx_controller
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic       byte_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  output logic       byte_ready,
  output logic       tx_bit,
  output logic       tx_eop,
  output logic       bit_strobe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] fsm_state
);

  // Byte handshake: a byte transfers on the rising edge where byte_valid and
  // byte_ready are both high; byte_ready is only raised on a LOAD decision, so
  // tx_byte/tx_last must stay stable while byte_valid is high until then.

  tx_state_e  state;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       last_flag;
  logic       aborted;
  logic [2:0] ones;

  logic       strobe;
  logic [2:0] ones_next;
  logic       stuff_due;
  logic       sync_end;
  logic       byte_end;
  logic       load_now;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (state == ST_IDLE),
    .enable (state != ST_IDLE),
    .strobe (strobe)
  );

  always_comb begin
    ones_next = tx_bit ? ones + 3'd1 : 3'd0;
    stuff_due = (state == ST_DATA) && (ones_next == STUFF_LIMIT);
    sync_end  = strobe && (state == ST_SYNC) && (bit_idx == 3'd7);
    // A stuff bit after bit 7 defers the byte boundary until the stuff bit ends.
    byte_end  = strobe && (bit_idx == 3'd7) &&
                (((state == ST_DATA) && !stuff_due) || (state == ST_STUFF));
    load_now  = sync_end || (byte_end && !last_flag);
  end

  assign byte_ready = load_now && byte_valid;
  assign bit_strobe = strobe;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      last_flag <= 1'b0;
      aborted   <= 1'b0;
      ones      <= 3'd0;
      tx_bit    <= 1'b1;
      tx_eop    <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        ST_IDLE: if (tx_start) begin
          state   <= ST_SYNC;
          tx_bit  <= SYNC_PATTERN[0];
          bit_idx <= 3'd0;
          ones    <= 3'd0;
          aborted <= 1'b0;
          tx_busy <= 1'b1;
        end
        ST_SYNC: if (strobe) begin
          ones <= ones_next;
          if (bit_idx != 3'd7) begin
            bit_idx <= bit_idx + 3'd1;
            tx_bit  <= SYNC_PATTERN[bit_idx + 3'd1];
          end
        end
        ST_DATA: if (strobe) begin
          if (stuff_due) begin
            state  <= ST_STUFF;
            tx_bit <= 1'b0;
            ones   <= 3'd0;
          end else begin
            ones <= ones_next;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              tx_bit  <= shift[bit_idx + 3'd1];
            end
          end
        end
        ST_STUFF: if (strobe) begin
          ones <= 3'd0;
          if (bit_idx != 3'd7) begin
            state   <= ST_DATA;
            bit_idx <= bit_idx + 3'd1;
            tx_bit  <= shift[bit_idx + 3'd1];
          end
        end
        ST_EOP: if (strobe) begin
          if (bit_idx == EOP_BITS - 3'd1) begin
            state   <= ST_EIDLE;
            tx_eop  <= 1'b0;
            tx_bit  <= 1'b1;
            bit_idx <= 3'd0;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_EIDLE: if (strobe) begin
          state    <= ST_IDLE;
          tx_done  <= 1'b1;
          tx_error <= aborted;
          tx_busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Byte boundaries override the per-state update above.
      if (load_now) begin
        if (byte_valid) begin
          shift     <= tx_byte;
          last_flag <= tx_last;
          state     <= ST_DATA;
          bit_idx   <= 3'd0;
          tx_bit    <= tx_byte[0];
        end else begin
          state   <= ST_EOP;
          tx_bit  <= 1'b1;
          tx_eop  <= 1'b1;
          bit_idx <= 3'd0;
          aborted <= 1'b1;
        end
      end else if (byte_end && last_flag) begin
        state   <= ST_EOP;
        tx_bit  <= 1'b1;
        tx_eop  <= 1'b1;
        bit_idx <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_controller.sv
// Directed bench for usb_tx_controller: serial stream, handshake timing, underrun, reset, back-to-back.
module tb_usb_tx_controller;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] tx_byte = 8'd0;
  logic       tx_last = 1'b0;
  logic       byte_ready, tx_bit, tx_eop, bit_strobe, tx_busy, tx_done, tx_error;
  logic [2:0] fsm_state;

  usb_tx_controller #(.CLKS_PER_BIT(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .byte_valid (byte_valid),
    .tx_byte    (tx_byte),
    .tx_last    (tx_last),
    .byte_ready (byte_ready),
    .tx_bit     (tx_bit),
    .tx_eop     (tx_eop),
    .bit_strobe (bit_strobe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int assert_cnt = 0;
  int fail_cnt = 0;

  // {tx_eop, tx_bit} per bit period
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic [8:0] feed_q[$];
  int         rdy_rel_q[$];
  int         start_cyc;
  int         done_rel;
  logic       err_seen;
  logic       rdy_seen;

  // driver tasks
  task automatic load_next();
    if (feed_q.size() > 0) begin
      {tx_last, tx_byte} = feed_q.pop_front();
      byte_valid = 1'b1;
    end else begin
      byte_valid = 1'b0;
    end
  endtask

  task automatic launch();
    @(negedge clk);
    tx_start = 1'b1;
    start_cyc = cyc + 1;
    load_next();
  endtask

  task automatic watch(input int max_cyc, input logic hold);
    obs_q.delete();
    rdy_rel_q.delete();
    done_rel = -1;
    err_seen = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!hold) tx_start = 1'b0;
      if (rdy_seen) load_next();
      rdy_seen = byte_ready && byte_valid;
      if (rdy_seen) rdy_rel_q.push_back(cyc - start_cyc);
      if (bit_strobe) obs_q.push_back({tx_eop, tx_bit});
      if (tx_done) begin
        done_rel = cyc - start_cyc;
        err_seen = tx_error;
        break;
      end
    end
  endtask

  // scoreboard helpers
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, v[i]});
  endtask

  task automatic push_eop();
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // tests
  task automatic test_reset();
    #12;
    assert_cnt++;
    if ({tx_bit, tx_eop, bit_strobe, tx_busy, tx_done, tx_error, byte_ready} !== 7'b1000000) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got %b want 1000000",
               {tx_bit, tx_eop, bit_strobe, tx_busy, tx_done, tx_error, byte_ready});
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    assert_cnt++;
    if ({tx_bit, tx_eop, bit_strobe, tx_busy, fsm_state} !== {4'b1000, ST_IDLE}) begin
      fail_cnt++;
      $display("FAIL idle_outputs: got %b state %0d want 1000 state %0d",
               {tx_bit, tx_eop, bit_strobe, tx_busy}, fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_single_00();
    int d;
    feed_q.push_back({1'b1, 8'h00});
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'h00, 8);
    push_eop();
    launch();
    watch(400, 1'b0);
    d = first_diff();
    assert_cnt++;
    if (d != -1) begin
      fail_cnt++;
      $display("FAIL stream_00: first diff at bit %0d, got %0d bits want %0d", d, obs_q.size(), exp_q.size());
    end
    assert_cnt++;
    if (done_rel != 152) begin
      fail_cnt++;
      $display("FAIL done_time_00: got %0d want 152", done_rel);
    end
    assert_cnt++;
    if (err_seen !== 1'b0 || tx_busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL done_flags_00: got err %b busy %b want 0 0", err_seen, tx_busy);
    end
    assert_cnt++;
    if (rdy_rel_q.size() != 1 || rdy_rel_q[0] != 63) begin
      fail_cnt++;
      $display("FAIL ready_00: got %0d pulses want 1 at 63", rdy_rel_q.size());
    end
  endtask

  task automatic test_single_ff();
    int d;
    feed_q.push_back({1'b1, 8'hFF});
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'h1DF, 9);
    push_eop();
    launch();
    watch(400, 1'b0);
    d = first_diff();
    assert_cnt++;
    if (d != -1) begin
      fail_cnt++;
      $display("FAIL stream_ff: first diff at bit %0d, got %0d bits want %0d", d, obs_q.size(), exp_q.size());
    end
    assert_cnt++;
    if (done_rel != 160 || err_seen !== 1'b0) begin
      fail_cnt++;
      $display("FAIL done_ff: got time %0d err %b want 160 0", done_rel, err_seen);
    end
  endtask

  task automatic test_two_bytes();
    int d;
    feed_q.push_back({1'b0, 8'hA5});
    feed_q.push_back({1'b1, 8'h3C});
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'h3CA5, 16);
    push_eop();
    launch();
    watch(400, 1'b0);
    d = first_diff();
    assert_cnt++;
    if (d != -1) begin
      fail_cnt++;
      $display("FAIL stream_two: first diff at bit %0d, got %0d bits want %0d", d, obs_q.size(), exp_q.size());
    end
    assert_cnt++;
    if (rdy_rel_q.size() != 2) begin
      fail_cnt++;
      $display("FAIL ready_count_two: got %0d want 2", rdy_rel_q.size());
    end else begin
      assert_cnt++;
      if (rdy_rel_q[0] != 63 || rdy_rel_q[1] != 127) begin
        fail_cnt++;
        $display("FAIL ready_time_two: got %0d,%0d want 63,127", rdy_rel_q[0], rdy_rel_q[1]);
      end
    end
    assert_cnt++;
    if (done_rel != 216 || err_seen !== 1'b0) begin
      fail_cnt++;
      $display("FAIL done_two: got time %0d err %b want 216 0", done_rel, err_seen);
    end
  endtask

  task automatic test_underrun();
    int d;
    feed_q.push_back({1'b0, 8'hA5});
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'hA5, 8);
    push_eop();
    launch();
    watch(400, 1'b0);
    d = first_diff();
    assert_cnt++;
    if (d != -1) begin
      fail_cnt++;
      $display("FAIL stream_underrun: first diff at bit %0d, got %0d bits want %0d", d, obs_q.size(), exp_q.size());
    end
    assert_cnt++;
    if (done_rel != 152 || err_seen !== 1'b1) begin
      fail_cnt++;
      $display("FAIL done_underrun: got time %0d err %b want 152 1", done_rel, err_seen);
    end
    assert_cnt++;
    if (rdy_rel_q.size() != 1) begin
      fail_cnt++;
      $display("FAIL ready_underrun: got %0d pulses want 1", rdy_rel_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d;
    logic saw_done;
    feed_q.push_back({1'b1, 8'h00});
    launch();
    watch(100, 1'b0);
    assert_cnt++;
    if (fsm_state !== ST_DATA || tx_busy !== 1'b1) begin
      fail_cnt++;
      $display("FAIL mid_state: got state %0d busy %b want %0d 1", fsm_state, tx_busy, ST_DATA);
    end
    n_rst = 1'b0;
    #1;
    assert_cnt++;
    if ({tx_bit, tx_eop, tx_busy, fsm_state} !== {3'b100, ST_IDLE}) begin
      fail_cnt++;
      $display("FAIL async_reset: got bit %b eop %b busy %b state %0d want 1 0 0 %0d",
               tx_bit, tx_eop, tx_busy, fsm_state, ST_IDLE);
    end
    @(negedge clk);
    n_rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done || tx_eop) saw_done = 1'b1;
    end
    assert_cnt++;
    if (saw_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL no_done_after_reset: got %b want 0", saw_done);
    end
    feed_q.push_back({1'b1, 8'h00});
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'h00, 8);
    push_eop();
    launch();
    watch(400, 1'b0);
    d = first_diff();
    assert_cnt++;
    if (d != -1 || done_rel != 152) begin
      fail_cnt++;
      $display("FAIL clean_after_reset: diff %0d done %0d want -1 152", d, done_rel);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    feed_q.push_back({1'b1, 8'h5A});
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'h5A, 8);
    push_eop();
    launch();
    watch(400, 1'b1);
    d = first_diff();
    assert_cnt++;
    if (d != -1 || done_rel != 152) begin
      fail_cnt++;
      $display("FAIL b2b_first: diff %0d done %0d want -1 152", d, done_rel);
    end
    assert_cnt++;
    if (fsm_state !== ST_IDLE || tx_busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_gap: got state %0d busy %b want %0d 0", fsm_state, tx_busy, ST_IDLE);
    end
    start_cyc = cyc + 1;
    feed_q.push_back({1'b1, 8'hC3});
    load_next();
    exp_q.delete();
    push_bits(32'h80, 8);
    push_bits(32'hC3, 8);
    push_eop();
    watch(400, 1'b1);
    d = first_diff();
    assert_cnt++;
    if (d != -1 || done_rel != 152) begin
      fail_cnt++;
      $display("FAIL b2b_second: diff %0d done %0d want -1 152", d, done_rel);
    end
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    assert_cnt++;
    if (fsm_state !== ST_IDLE || tx_busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_stop: got state %0d busy %b want %0d 0", fsm_state, tx_busy, ST_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single_00();
    test_single_ff();
    test_two_bytes();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
